tone_pwm_mixer: RTL and testbench
=================================

TONE_PWM_MIXER -- requirements
Module: tone_pwm_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of tone channels (1..8).
REQ-002 SHALL have parameter PER_W, default 16, half-period field width in clk cycles.
REQ-003 SHALL have parameter DUR_W, default 12, duration field width in ticks.
REQ-004 SHALL have parameter VOL_W, default 4, per-channel volume width.
REQ-005 SHALL have parameter TICK_DIV, default 50000, clk cycles per duration tick (1 ms at 50 MHz).
REQ-006 SHALL have port clk  in  1  core clock; one clock only.
REQ-007 SHALL have port rstn  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port cmd_valid  in  1  command strobe.
REQ-009 SHALL have port cmd_ch  in  3  target channel index.
REQ-010 SHALL have port cmd_half_per  in  PER_W  square half-period; 0 = silent.
REQ-011 SHALL have port cmd_dur  in  DUR_W  duration in ticks; 0 = stop channel.
REQ-012 SHALL have port cmd_vol  in  VOL_W  channel volume.
REQ-013 SHALL have port cmd_err  out  1  one-cycle pulse: cmd_ch >= NUM_CH.
REQ-014 SHALL have port ch_busy  out  NUM_CH  per-channel PLAY status.
REQ-015 SHALL have port ch_done  out  NUM_CH  one-cycle pulse on natural expiry.
REQ-016 SHALL have port aud_pwm  out  1  PWM audio bit.
REQ-017 SHALL have port aud_sd  out  1  amplifier enable, = OR of ch_busy.

Function
REQ-018 SHALL accept a command every cycle cmd_valid=1; no back-pressure; the command is applied in the same clock edge.
REQ-019 SHALL run per-channel FSM IDLE/PLAY; valid command with cmd_dur!=0 -> PLAY (ch_busy=1 next cycle), loading period, duration, volume, phase=1, phase counter=0.
REQ-020 SHALL, on a command to a channel already in PLAY, retrigger (reload all fields, phase=1); no ch_done.
REQ-021 SHALL, on cmd_dur=0, force channel to IDLE next cycle without ch_done.
REQ-022 SHALL, in PLAY with half_per!=0, toggle phase when phase counter reaches half_per-1, then clear counter; half_per=0 holds phase=0.
REQ-023 SHALL run one free-running TICK_DIV prescaler shared by all channels, not reset by commands.
REQ-024 SHALL decrement each PLAY duration counter on tick; at 1->0 channel goes IDLE and ch_done pulses one cycle.
REQ-025 SHALL give a command priority over same-cycle expiry: command applied, no ch_done.
REQ-026 SHALL compute mix = sum of vol over channels with busy & phase, width PWM_W = VOL_W+clog2(NUM_CH), no overflow.
REQ-027 SHALL run PWM_W-bit free-running pwm counter; latch mix only at counter==0; aud_pwm = (counter < latched mix), registered.
REQ-028 SHALL ignore and pulse cmd_err for cmd_ch >= NUM_CH; no channel state change.

Reset
REQ-029 SHALL, on rstn=0, clear all channels to IDLE, prescaler, pwm counter and latched mix to 0; ch_busy, ch_done, cmd_err, aud_pwm, aud_sd = 0.
REQ-030 SHALL, on reset mid-tone, silence immediately with no ch_done after release.

Configuration
REQ-031 SHALL support macro TONE_PWM_MIXER_FADE_EN; defined: each PLAY channel volume decrements by 1 every 16 ticks, floor 1; undefined: volume constant for the tone.

Structure
REQ-032 SHALL place channel-state enum, channel command struct and default TICK_DIV constant in package tone_pwm_pkg.
REQ-033 SHALL implement one channel as sub-module tone_channel, instantiated NUM_CH times via generate.

Verification
REQ-034 SHALL test: TICK_DIV=10, ch0 half_per=3 dur=2 vol=15 -> phase toggles every 3 cycles, ch_done[0] after 2 ticks, ch_busy[0] low next cycle.
REQ-035 SHALL test: all 4 channels vol=15 phase high -> latched mix=60, aud_pwm high 60 of 64 cycles.
REQ-036 SHALL test: retrigger ch1 one cycle before expiry -> no ch_done[1], new duration honoured.
REQ-037 SHALL test: cmd_ch=5 with NUM_CH=4 -> cmd_err one cycle, ch_busy unchanged.
REQ-038 SHALL test: rstn low mid-tone -> all outputs 0 asynchronously, no ch_done after release.
REQ-039 SHALL test with TONE_PWM_MIXER_FADE_EN: vol=3 dur=100 -> vol 2 after 16 ticks, 1 after 32, stays 1.

Source files
------------

// File: rtl/tone_pwm_mixer_pkg.sv
// ---------------------------------------------------------------------------
// tone_pwm_pkg
// Shared types for the tone / PWM mixer block.
//   ch_state_t  : per-channel FSM state (IDLE / PLAY)
//   ch_cmd_t    : decoded per-channel command strobes (load / stop)
//   TICK_DIV_DEF: default clk cycles per duration tick (1 ms at 50 MHz)
// ---------------------------------------------------------------------------
package tone_pwm_pkg;

  localparam int TICK_DIV_DEF = 50000;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PLAY = 1'b1
  } ch_state_t;

  // load: valid command to this channel with a non-zero duration
  // stop: valid command to this channel with duration 0
  typedef struct packed {
    logic load;
    logic stop;
  } ch_cmd_t;

endpackage

// File: rtl/tone_pwm_mixer_if.sv
// ---------------------------------------------------------------------------
// tone_pwm_mixer_if
// Command bus of the tone mixer. No back-pressure: a command is taken in
// every cycle cmd_valid is high.
//   cmd_valid    : command strobe
//   cmd_ch       : target channel index
//   cmd_half_per : square-wave half-period in clk cycles (0 = silent)
//   cmd_dur      : duration in ticks (0 = stop channel)
//   cmd_vol      : channel volume
//   cmd_err      : one-cycle pulse when cmd_ch addresses no channel
// Modports: master (command source), slave (mixer).
// ---------------------------------------------------------------------------
interface tone_pwm_mixer_if #(
  parameter int PER_W = 16,
  parameter int DUR_W = 12,
  parameter int VOL_W = 4
);
  logic             cmd_valid;
  logic [2:0]       cmd_ch;
  logic [PER_W-1:0] cmd_half_per;
  logic [DUR_W-1:0] cmd_dur;
  logic [VOL_W-1:0] cmd_vol;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_ch, cmd_half_per, cmd_dur, cmd_vol,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_half_per, cmd_dur, cmd_vol,
    output cmd_err
  );
endinterface

// File: rtl/tone_pwm_mixer_channel.sv
// ---------------------------------------------------------------------------
// tone_channel
// One square-wave tone channel: IDLE/PLAY FSM, half-period phase counter,
// tick-based duration counter and volume register.
// Optional feature macro TONE_PWM_MIXER_FADE_EN: volume steps down by 1
// every 16 ticks while playing, never below 1.
// Ports:
//   clk, rstn  : core clock, async active-low reset
//   cmd        : decoded load/stop strobes for this channel
//   half_per, dur, vol : command fields, sampled on load
//   tick       : shared duration prescaler strobe
//   busy       : channel is in PLAY
//   done       : one-cycle pulse on natural expiry
//   phase      : current square-wave level
//   vol_out    : current volume
// ---------------------------------------------------------------------------
module tone_channel
  import tone_pwm_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int DUR_W = 12,
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  ch_cmd_t          cmd,
  input  logic [PER_W-1:0] half_per,
  input  logic [DUR_W-1:0] dur,
  input  logic [VOL_W-1:0] vol,
  input  logic             tick,
  output logic             busy,
  output logic             done,
  output logic             phase,
  output logic [VOL_W-1:0] vol_out
);

  ch_state_t        state_q, state_nxt;
  logic             expire;
  logic             done_q;
  logic             phase_q;
  logic [PER_W-1:0] hp_q, pcnt_q;
  logic [DUR_W-1:0] dur_q;
  logic [VOL_W-1:0] vol_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= CH_IDLE;
    else       state_q <= state_nxt;
  end

  // A command always wins over a same-cycle expiry.
  always_comb begin
    state_nxt = state_q;
    expire    = 1'b0;
    unique case (state_q)
      CH_IDLE: if (cmd.load) state_nxt = CH_PLAY;
      CH_PLAY: begin
        if (cmd.load)      state_nxt = CH_PLAY;
        else if (cmd.stop) state_nxt = CH_IDLE;
        else if (tick && dur_q == DUR_W'(1)) begin
          state_nxt = CH_IDLE;
          expire    = 1'b1;
        end
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == CH_PLAY);
    done    = done_q;
    phase   = phase_q;
    vol_out = vol_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) done_q <= 1'b0;
    else       done_q <= expire;
  end

  // A silent tone (half_per = 0) starts and stays at phase 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hp_q    <= '0;
      pcnt_q  <= '0;
      dur_q   <= '0;
      phase_q <= 1'b0;
    end else if (cmd.load) begin
      hp_q    <= half_per;
      pcnt_q  <= '0;
      dur_q   <= dur;
      phase_q <= |half_per;
    end else if (state_q == CH_PLAY) begin
      if (hp_q == '0) begin
        phase_q <= 1'b0;
        pcnt_q  <= '0;
      end else if (pcnt_q == hp_q - PER_W'(1)) begin
        phase_q <= ~phase_q;
        pcnt_q  <= '0;
      end else begin
        pcnt_q  <= pcnt_q + PER_W'(1);
      end
      if (tick) dur_q <= dur_q - DUR_W'(1);
    end else begin
      phase_q <= 1'b0;
    end
  end

`ifdef TONE_PWM_MIXER_FADE_EN
  logic [3:0] fade_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          fade_q <= '0;
    else if (cmd.load)                  fade_q <= '0;
    else if (state_q == CH_PLAY && tick) fade_q <= fade_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         vol_q <= '0;
    else if (cmd.load) vol_q <= vol;
    else if (state_q == CH_PLAY && tick && fade_q == 4'hF && vol_q > VOL_W'(1))
      vol_q <= vol_q - VOL_W'(1);
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         vol_q <= '0;
    else if (cmd.load) vol_q <= vol;
  end
`endif

endmodule

// File: rtl/tone_pwm_mixer.sv
// ---------------------------------------------------------------------------
// tone_pwm_mixer
// NUM_CH square-wave tone channels mixed by volume into a 1-bit PWM stream.
// Optional feature macro TONE_PWM_MIXER_FADE_EN enables per-channel volume
// fade (see tone_channel).
// Ports:
//   clk, rstn : core clock, async active-low reset
//   cmd       : command bus (slave modport), includes cmd_err pulse
//   ch_busy   : per-channel PLAY status
//   ch_done   : per-channel one-cycle pulse on natural expiry
//   aud_pwm   : registered PWM audio bit
//   aud_sd    : amplifier enable, high while any channel plays
// ---------------------------------------------------------------------------
module tone_pwm_mixer
  import tone_pwm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PER_W    = 16,
  parameter int DUR_W    = 12,
  parameter int VOL_W    = 4,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  tone_pwm_mixer_if.slave   cmd,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_done,
  output logic              aud_pwm,
  output logic              aud_sd
);

  localparam int PWM_W = VOL_W + $clog2(NUM_CH);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] presc_q;
  logic             tick;
  logic             in_range;
  logic             cmd_err_q;
  logic [NUM_CH-1:0] ch_phase;
  logic [VOL_W-1:0]  ch_vol [NUM_CH];

  // Free-running prescaler shared by all channels; commands never touch it.
  assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PRE_W'(1);
  end

  assign in_range = ({1'b0, cmd.cmd_ch} < 4'(NUM_CH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cmd_err_q <= 1'b0;
    else       cmd_err_q <= cmd.cmd_valid && !in_range;
  end

  assign cmd.cmd_err = cmd_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_cmd_t c_cmd;
    logic    hit;

    assign hit        = cmd.cmd_valid && (cmd.cmd_ch == 3'(i));
    assign c_cmd.load = hit && (cmd.cmd_dur != '0);
    assign c_cmd.stop = hit && (cmd.cmd_dur == '0);

    tone_channel #(
      .PER_W (PER_W),
      .DUR_W (DUR_W),
      .VOL_W (VOL_W)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .cmd      (c_cmd),
      .half_per (cmd.cmd_half_per),
      .dur      (cmd.cmd_dur),
      .vol      (cmd.cmd_vol),
      .tick     (tick),
      .busy     (ch_busy[i]),
      .done     (ch_done[i]),
      .phase    (ch_phase[i]),
      .vol_out  (ch_vol[i])
    );
  end

  assign aud_sd = |ch_busy;

  // Stage p0: combinational mix of all sounding channels.
  logic [PWM_W-1:0] mix_p0;

  always_comb begin
    mix_p0 = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_busy[i] && ch_phase[i]) mix_p0 = mix_p0 + PWM_W'(ch_vol[i]);
  end

  // Stage p1: PWM compare. The mix is sampled only at counter wrap so each
  // PWM period uses one consistent duty value.
  logic [PWM_W-1:0] pwm_cnt_q, mix_lat_q, mix_eff;
  logic             aud_pwm_p1;

  assign mix_eff = (pwm_cnt_q == '0) ? mix_p0 : mix_lat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt_q  <= '0;
      mix_lat_q  <= '0;
      aud_pwm_p1 <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_q + PWM_W'(1);
      mix_lat_q  <= mix_eff;
      aud_pwm_p1 <= (pwm_cnt_q < mix_eff);
    end
  end

  assign aud_pwm = aud_pwm_p1;

endmodule

// File: tb/tb_tone_pwm_mixer.sv
// ---------------------------------------------------------------------------
// tb_tone_pwm_mixer
// Self-checking bench for tone_pwm_mixer (NUM_CH=4, TICK_DIV=10). A
// cycle-level reference model derives channel activity from elapsed cycles
// and ticks since each command; outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_tone_pwm_mixer;
  localparam int NUM_CH = 4;
  localparam int PER_W  = 16;
  localparam int DUR_W  = 12;
  localparam int VOL_W  = 4;
  localparam int TD     = 10;
  localparam int PWM_N  = 64;
  localparam int VW     = 2 * NUM_CH + 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NUM_CH-1:0] ch_busy, ch_done;
  logic aud_pwm, aud_sd;

  tone_pwm_mixer_if #(.PER_W(PER_W), .DUR_W(DUR_W), .VOL_W(VOL_W)) cif ();

  tone_pwm_mixer #(
    .NUM_CH(NUM_CH), .PER_W(PER_W), .DUR_W(DUR_W), .VOL_W(VOL_W), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd(cif),
    .ch_busy(ch_busy), .ch_done(ch_done), .aud_pwm(aud_pwm), .aud_sd(aud_sd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int edge_n;
  bit m_busy [NUM_CH];
  bit m_done [NUM_CH];
  int m_rem  [NUM_CH];
  int m_hp   [NUM_CH];
  int m_vol  [NUM_CH];
  int m_k    [NUM_CH];
  int m_t    [NUM_CH];
  int m_lat;
  bit m_aud, m_err;

  function automatic bit f_phase(int c);
    if (m_hp[c] == 0) return 1'b0;
    return ((m_k[c] / m_hp[c]) % 2) == 0;
  endfunction

  function automatic int f_vol(int c);
`ifdef TONE_PWM_MIXER_FADE_EN
    int v;
    if (m_vol[c] <= 1) return m_vol[c];
    v = m_vol[c] - m_t[c] / 16;
    return (v < 1) ? 1 : v;
`else
    return m_vol[c];
`endif
  endfunction

  function automatic logic [VW-1:0] f_exp();
    logic [NUM_CH-1:0] b, d;
    for (int c = 0; c < NUM_CH; c++) begin
      b[c] = m_busy[c];
      d[c] = m_done[c];
    end
    return {b, d, m_err, m_aud, |b};
  endfunction

  function automatic logic [VW-1:0] f_act();
    return {ch_busy, ch_done, cif.cmd_err, aud_pwm, aud_sd};
  endfunction

  task automatic model_reset();
    edge_n = 0;
    m_lat = 0; m_aud = 0; m_err = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_busy[c] = 0; m_done[c] = 0; m_rem[c] = 0; m_hp[c] = 0;
      m_vol[c] = 0; m_k[c] = 0; m_t[c] = 0;
    end
  endtask

  // Advance the model across one clock edge using the current inputs, then
  // move the DUT across the same edge.
  task automatic step();
    bit tick;
    int pc, mixv;
    edge_n++;
    tick = ((edge_n - 1) % TD) == TD - 1;
    pc   = (edge_n - 1) % PWM_N;
    mixv = 0;
    for (int c = 0; c < NUM_CH; c++)
      if (m_busy[c] && f_phase(c)) mixv += f_vol(c);
    if (pc == 0) m_lat = mixv;
    m_aud = pc < m_lat;
    m_err = cif.cmd_valid && (int'(cif.cmd_ch) >= NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      m_done[c] = 0;
      if (cif.cmd_valid && int'(cif.cmd_ch) == c) begin
        if (cif.cmd_dur != 0) begin
          m_busy[c] = 1; m_rem[c] = int'(cif.cmd_dur); m_hp[c] = int'(cif.cmd_half_per);
          m_vol[c] = int'(cif.cmd_vol); m_k[c] = 0; m_t[c] = 0;
        end else begin
          m_busy[c] = 0;
        end
      end else if (m_busy[c]) begin
        m_k[c]++;
        if (tick) begin
          m_t[c]++;
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_busy[c] = 0;
            m_done[c] = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int ch, int hp, int dur, int vol);
    cif.cmd_valid    = 1'b1;
    cif.cmd_ch       = 3'(ch);
    cif.cmd_half_per = PER_W'(hp);
    cif.cmd_dur      = DUR_W'(dur);
    cif.cmd_vol      = VOL_W'(vol);
  endtask

  task automatic test_reset();
    cif.cmd_valid = 0; cif.cmd_ch = '0; cif.cmd_half_per = '0;
    cif.cmd_dur = '0; cif.cmd_vol = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (f_act() !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%b exp=%b", f_act(), {VW{1'b0}});
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
    end
  endtask

  task automatic test_tone();
    int dones = 0;
    send(0, 3, 2, 15);
    for (int i = 0; i < 30; i++) begin
      step();
      cif.cmd_valid = 0;
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL tone cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
      if (m_busy[0]) begin
        n_cmp++;
        if (dut.ch_phase[0] !== f_phase(0)) begin
          n_bad++;
          $display("FAIL tone_phase cyc=%0d got=%b exp=%b", i, dut.ch_phase[0], f_phase(0));
        end
      end
      if (ch_done[0] === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL tone_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_mix_full();
    int hi = 0;
    for (int i = 0; i < 220; i++) begin
      if (i < NUM_CH) send(i, 1000, 20, 15);
      else cif.cmd_valid = 0;
      step();
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL mix_full cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
      if (i >= 70 && i < 70 + PWM_N && aud_pwm === 1'b1) hi++;
    end
    cif.cmd_valid = 0;
    n_cmp++;
    if (hi != 60) begin
      n_bad++;
      $display("FAIL mix_full_duty got=%0d exp=60", hi);
    end
  endtask

  task automatic test_retrigger();
    bit r1 = 0, r2 = 0;
    int t1 = -1000, t2 = -1000, d1 = 0, d2 = 0, dc1 = 0, dc2 = 0;
    send(1, 5, 3, 7);
    step();
    send(2, 5, 3, 9);
    step();
    for (int i = 0; i < 120; i++) begin
      cif.cmd_valid = 0;
      if (!r1 && m_busy[1] && m_rem[1] == 1 && (edge_n % TD) == TD - 2) begin
        send(1, 5, 4, 7); r1 = 1; t1 = i;
      end else if (!r2 && m_busy[2] && m_rem[2] == 1 && (edge_n % TD) == TD - 1) begin
        send(2, 5, 4, 9); r2 = 1; t2 = i;
      end
      step();
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL retrigger cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
      if (ch_done[1] === 1'b1) begin d1++; dc1 = i; end
      if (ch_done[2] === 1'b1) begin d2++; dc2 = i; end
    end
    cif.cmd_valid = 0;
    n_cmp++;
    if (d1 != 1 || dc1 - t1 != 31) begin
      n_bad++;
      $display("FAIL retrig_early dones=%0d delay=%0d exp dones=1 delay=31", d1, dc1 - t1);
    end
    n_cmp++;
    if (d2 != 1 || dc2 - t2 != 40) begin
      n_bad++;
      $display("FAIL retrig_same_cycle dones=%0d delay=%0d exp dones=1 delay=40", d2, dc2 - t2);
    end
  endtask

  task automatic test_err();
    send(3, 2, 50, 5);
    step();
    for (int i = 0; i < 4; i++) begin
      send(4 + i, $urandom_range(1, 100), $urandom_range(1, 100), $urandom_range(0, 15));
      step();
      n_cmp++;
      if (cif.cmd_err !== 1'b1 || ch_busy !== 4'b1000) begin
        n_bad++;
        $display("FAIL err_pulse ch=%0d got err=%b busy=%b exp err=1 busy=1000",
                 4 + i, cif.cmd_err, ch_busy);
      end
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL err_model ch=%0d got=%b exp=%b", 4 + i, f_act(), f_exp());
      end
    end
    cif.cmd_valid = 0;
    step();
    n_cmp++;
    if (cif.cmd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear got=%b exp=0", cif.cmd_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      if (i < 16) send($urandom_range(0, 3), $urandom_range(1, 4),
                       $urandom_range(1, 3), $urandom_range(0, 15));
      else cif.cmd_valid = 0;
      step();
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0)
        send($urandom_range(0, 7), $urandom_range(0, 6),
             $urandom_range(0, 4), $urandom_range(0, 15));
      else cif.cmd_valid = 0;
      step();
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
    end
    cif.cmd_valid = 0;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < NUM_CH) send(i, 2, 5, 9);
      else cif.cmd_valid = 0;
      step();
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL pre_reset cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
    end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (f_act() !== '0) begin
      n_bad++;
      $display("FAIL async_reset got=%b exp=%b", f_act(), {VW{1'b0}});
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
      if (ch_done !== '0) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL post_reset_done got=%0d exp=0", dones);
    end
  endtask

  task automatic test_fade();
    int w [4];
    int ws [4] = '{70, 240, 400, 800};
    int we [4];
`ifdef TONE_PWM_MIXER_FADE_EN
    we = '{3, 2, 1, 1};
`else
    we = '{3, 3, 3, 3};
`endif
    w = '{0, 0, 0, 0};
    send(0, 60000, 100, 3);
    for (int i = 0; i < 1010; i++) begin
      step();
      cif.cmd_valid = 0;
      n_cmp++;
      if (f_act() !== f_exp()) begin
        n_bad++;
        $display("FAIL fade cyc=%0d got=%b exp=%b", i, f_act(), f_exp());
      end
      for (int j = 0; j < 4; j++)
        if (i >= ws[j] && i < ws[j] + PWM_N && aud_pwm === 1'b1) w[j]++;
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (w[j] != we[j]) begin
        n_bad++;
        $display("FAIL fade_duty win=%0d got=%0d exp=%0d", j, w[j], we[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_mix_full();
    test_retrigger();
    test_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_fade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
